// File: rtl/trace_pkg.sv
// Shared definitions for the instruction-fetch trace buffer: state encoding,
// default geometry and a saturating counter helper.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_POST = 2'b10,
    ST_DONE = 2'b11
  } trace_state_e;

  localparam int TRACE_DEPTH    = 8;
  localparam int TRACE_POST_CNT = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x 64-bit register array, one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
module trace_ram #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_cpu,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [63:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [63:0]              rdata
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk_cpu) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_buf.sv
// Instruction-fetch trace buffer: records {pc, instr} on each IRWrite while
// armed, with an optional PC-match trigger followed by POST_CNT more fetches.
//
// state | meaning
// IDLE  | not armed, fetches ignored
// RUN   | capturing, watching for the trigger PC
// POST  | trigger seen, capturing the remaining post-trigger fetches
// DONE  | trace frozen until arm or clr
module trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH    = TRACE_DEPTH,
  parameter int POST_CNT = TRACE_POST_CNT
) (
  input  logic                     clk_cpu,
  input  logic                     rst_cpu,
  input  logic                     ir_write,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic                     arm,
  input  logic                     clr,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic [$clog2(DEPTH)-1:0] rd_sel,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow,
  output logic [15:0]              instr_cnt,
  output logic [15:0]              cycle_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(POST_CNT + 2);

  trace_state_e   state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [PW-1:0]  post_q, post_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    instr_cnt_q, instr_cnt_d;
  logic [15:0]    cycle_cnt_q, cycle_cnt_d;

  logic           capture;
  logic           trig_hit;
  logic [AW-1:0]  rd_idx;
  logic [63:0]    rd_data;

  always_comb begin
    capture     = ir_write && !clr && (state_q == ST_RUN || state_q == ST_POST);
    trig_hit    = trig_en && (pc == trig_pc);
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_d      = post_q;
    overflow_d  = overflow_q;
    instr_cnt_d = instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    if (clr) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      count_d     = '0;
      post_d      = '0;
      overflow_d  = 1'b0;
      instr_cnt_d = '0;
      cycle_cnt_d = '0;
    end else begin
      if (capture) begin
        wr_ptr_d    = wr_ptr_q + AW'(1);
        instr_cnt_d = instr_cnt_q + 16'd1;
        if (count_q == (AW+1)'(DEPTH)) overflow_d = 1'b1;
        else                           count_d    = count_q + (AW+1)'(1);
      end
      if (state_q == ST_RUN || state_q == ST_POST) cycle_cnt_d = sat_inc16(cycle_cnt_q);

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d     = ST_RUN;
            wr_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            overflow_d  = 1'b0;
            instr_cnt_d = '0;
            cycle_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (capture && trig_hit) begin
            if (POST_CNT == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
              post_d  = PW'(POST_CNT);
            end
          end
        end
        ST_POST: begin
          if (capture) begin
            post_d = post_q - PW'(1);
            if (post_q == PW'(1)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      overflow_q  <= 1'b0;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      overflow_q  <= overflow_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_cpu (clk_cpu),
    .we      (capture),
    .waddr   (wr_ptr_q),
    .wdata   ({pc, instr}),
    .raddr   (rd_idx),
    .rdata   (rd_data)
  );

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign rd_idx    = wr_ptr_q - AW'(1) - rd_sel;
  assign rd_valid  = ({1'b0, rd_sel} < count_q);
  assign rd_pc     = rd_valid ? rd_data[63:32] : 32'd0;
  assign rd_instr  = rd_valid ? rd_data[31:0]  : 32'd0;
  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = overflow_q;
  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule
